// File: rtl/reg_wb_pkg.sv
// reg_wb_pkg: shared widths, source indices and slot type for the writeback arbiter.
// Rev 1.0
`default_nettype none

package reg_wb_pkg;

  localparam int NUM_SRC   = 3;
  localparam int DATA_BITS = 8;
  localparam int ADDR_BITS = 4;
  localparam int RO_BASE   = 13;

  localparam int SRC_ALU   = 0;
  localparam int SRC_LSU   = 1;
  localparam int SRC_CONST = 2;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data;
  } slot_t;

endpackage

`default_nettype wire

// File: rtl/reg_write_arbiter_rr_pick.sv
// rr_pick: cyclic first-set finder; grants the first requesting index at or after ptr.
// Rev 1.0
`default_nettype none

module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          any
);

  int idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx[PW-1:0]]) begin
        grant[idx[PW-1:0]] = 1'b1;
        any                = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin share of one register-file write port among writeback sources.
// Optional macro WB_DROP_RO_EN discards writes to read-only registers. Rev 1.0
`default_nettype none

module reg_write_arbiter
  import reg_wb_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic [NUM_SRC*ADDR_BITS-1:0]  src_addr,
  input  logic [NUM_SRC*DATA_BITS-1:0]  src_data,
  output logic                          wr_en,
  output logic [ADDR_BITS-1:0]          wr_addr,
  output logic [DATA_BITS-1:0]          wr_data,
  output logic                          drop_err,
  output logic [2**ADDR_BITS-1:0]       pend_mask,
  output logic                          busy
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] held;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] accept;
  logic               any;
  logic               wr_go;
  slot_t              slots [NUM_SRC];
  slot_t              sel;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   ptr_next;

  // Grant depends only on registered slot state and enable, never on src_valid.
  assign req = enable ? held : '0;

  rr_pick #(.N(NUM_SRC), .PW(PTR_W)) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant),
    .any   (any)
  );

  assign src_ready = ~held | grant;
  assign accept    = src_valid & src_ready;
  assign busy      = |held;

  always_comb begin
    sel      = '0;
    ptr_next = rr_ptr;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        sel      = slots[i];
        ptr_next = (i == NUM_SRC - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (held[i]) pend_mask[slots[i].addr] = 1'b1;
    end
  end

`ifdef WB_DROP_RO_EN
  logic is_ro;
  assign is_ro = (sel.addr >= ADDR_BITS'(RO_BASE));
  assign wr_go = any && !is_ro;

  always_ff @(posedge clk) begin
    if (!reset) drop_err <= 1'b0;
    else        drop_err <= any && is_ro;
  end
`else
  assign wr_go    = any;
  assign drop_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      held    <= '0;
      rr_ptr  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      held  <= accept | (held & ~grant);
      wr_en <= wr_go;
      if (any) begin
        rr_ptr  <= ptr_next;
        wr_addr <= sel.addr;
        wr_data <= sel.data;
      end
    end
  end

  // Slot payload needs no reset: it is only observed while its held bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (accept[i]) begin
        slots[i].addr <= src_addr[i*ADDR_BITS +: ADDR_BITS];
        slots[i].data <= src_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed vectors with hand-computed expectations for reg_write_arbiter.
// Rev 1.0
`default_nettype none

module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  src_valid;
  logic [2:0]  src_ready;
  logic [11:0] src_addr;
  logic [23:0] src_data;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        drop_err;
  logic [15:0] pend_mask;
  logic        busy;

  int n_vec = 0;
  int n_mis = 0;

  reg_write_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_addr  (src_addr),
    .src_data  (src_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .drop_err  (drop_err),
    .pend_mask (pend_mask),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [3:0] a, input logic [7:0] d);
    src_addr[s*4 +: 4] = a;
    src_data[s*8 +: 8] = d;
  endtask

  task automatic check_write(input string tag, input logic [3:0] a, input logic [7:0] d);
    check_vec({tag, "_en"}, 32'(wr_en), 32'd1);
    check_vec({tag, "_addr"}, 32'(wr_addr), 32'(a));
    check_vec({tag, "_data"}, 32'(wr_data), 32'(d));
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b1;
    src_valid = 3'b111;
    src_addr  = '0;
    src_data  = '0;

    // Reset held with all sources requesting
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clk);
      check_vec("rst_ready", 32'(src_ready), 32'h7);
      check_vec("rst_wr_en", 32'(wr_en), 32'd0);
      check_vec("rst_busy", 32'(busy), 32'd0);
      check_vec("rst_pend", 32'(pend_mask), 32'd0);
    end
    check_vec("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_vec("rst_drop", 32'(drop_err), 32'd0);
    step();
    src_valid = 3'b000;
    reset     = 1'b1;
    step();

    // Single ALU write: addr 3 / 0x2A
    set_src(0, 4'd3, 8'h2A);
    src_valid = 3'b001;
    step();                       // edge E accepts
    src_valid = 3'b000;
    @(negedge clk);
    check_vec("alu_pend", 32'(pend_mask), 32'h0008);
    check_vec("alu_busy", 32'(busy), 32'd1);
    check_vec("alu_pre_en", 32'(wr_en), 32'd0);
    step();                       // edge E+1 grants
    @(negedge clk);
    check_write("alu_wr", 4'd3, 8'h2A);
    check_vec("alu_pend_clr", 32'(pend_mask), 32'd0);
    step();
    @(negedge clk);
    check_vec("alu_post_en", 32'(wr_en), 32'd0);

    // Reset pulse returns rr_ptr to 0
    reset = 1'b0;
    step();
    reset = 1'b1;

    // Three-way contention: addrs 1,2,4
    set_src(0, 4'd1, 8'h11);
    set_src(1, 4'd2, 8'h22);
    set_src(2, 4'd4, 8'h44);
    src_valid = 3'b111;
    step();
    src_valid = 3'b000;
    @(negedge clk);
    check_vec("rr_pend", 32'(pend_mask), 32'h0016);
    step();
    @(negedge clk);
    check_write("rr_w0", 4'd1, 8'h11);
    step();
    @(negedge clk);
    check_write("rr_w1", 4'd2, 8'h22);
    step();
    @(negedge clk);
    check_write("rr_w2", 4'd4, 8'h44);
    step();
    @(negedge clk);
    check_vec("rr_idle", 32'(wr_en), 32'd0);

    // rr_ptr back at 0: ALU beats LSU
    set_src(0, 4'd5, 8'h55);
    set_src(1, 4'd6, 8'h66);
    src_valid = 3'b011;
    step();
    src_valid = 3'b000;
    step();
    @(negedge clk);
    check_write("ptr0_w0", 4'd5, 8'h55);
    step();
    @(negedge clk);
    check_write("ptr0_w1", 4'd6, 8'h66);

    // CONST to a read-only register
    set_src(2, 4'd14, 8'h55);
    src_valid = 3'b100;
    step();
    src_valid = 3'b000;
    step();
    @(negedge clk);
`ifdef WB_DROP_RO_EN
    check_vec("ro_wr_en", 32'(wr_en), 32'd0);
    check_vec("ro_drop", 32'(drop_err), 32'd1);
    step();
    @(negedge clk);
    check_vec("ro_drop_end", 32'(drop_err), 32'd0);
`else
    check_write("ro_wr", 4'd14, 8'h55);
    check_vec("ro_drop", 32'(drop_err), 32'd0);
    step();
`endif
    check_vec("ro_busy", 32'(busy), 32'd0);

    // enable low with LSU slot held
    enable = 1'b0;
    set_src(1, 4'd9, 8'h99);
    src_valid = 3'b010;
    step();
    src_valid = 3'b000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_vec("dis_wr_en", 32'(wr_en), 32'd0);
      check_vec("dis_ready1", 32'(src_ready[1]), 32'd0);
      check_vec("dis_busy", 32'(busy), 32'd1);
      step();
    end
    enable = 1'b1;
    step();
    @(negedge clk);
    check_write("en_wr", 4'd9, 8'h99);

    // ALU streams addrs 0..7
    step();
    for (int k = 0; k < 11; k++) begin
      if (k < 8) begin
        set_src(0, 4'(k), 8'(8'hA0 + k));
        src_valid = 3'b001;
      end else begin
        src_valid = 3'b000;
      end
      @(negedge clk);
      if (k < 8) check_vec("str_ready", 32'(src_ready[0]), 32'd1);
      if (k >= 2 && k < 10) check_write("str_wr", 4'(k - 2), 8'(8'hA0 + k - 2));
      if (k == 10) check_vec("str_end", 32'(wr_en), 32'd0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
